// File: rtl/sync_pattern_gen_if.sv
// Bus between the pattern generator and its consumer: control inputs
// (en, mode) plus the simulated ADC-side signals and the ramp data strobe.
interface sync_pattern_gen_if #(
    parameter int NCHN      = 1,
    parameter int DATA_NBIT = 18
);
    logic                 en;
    logic [1:0]           mode;
    logic                 out_spclk;
    logic                 out_sync;
    logic [NCHN-1:0]      out_data;
    logic                 frame_start;
    // pat_vd is a one-cycle valid strobe with no ready: the consumer must
    // take pat_data on the cycle pat_vd is high, there is no back-pressure.
    logic                 pat_vd;
    logic [DATA_NBIT-1:0] pat_data;

    modport master (
        input  en, mode,
        output out_spclk, out_sync, out_data, frame_start, pat_vd, pat_data
    );

    modport slave (
        output en, mode,
        input  out_spclk, out_sync, out_data, frame_start, pat_vd, pat_data
    );
endinterface

// File: rtl/sync_pattern_gen.sv
// Frame-sync, sample-clock and test-pattern generator for the ADC acquisition
// path; NCHN phase-staggered serial channels and a ramp data word, all on mclk.
module sync_pattern_gen #(
    parameter int DIV       = 500,
    parameter int FRAME_LEN = 512,
    parameter int SYNC_LEN  = 9,
    parameter int NCHN      = 1,
    parameter int DATA_NBIT = 18
) (
    input  logic               mclk,
    input  logic               rst,
    sync_pattern_gen_if.master pg
);

    localparam int DIV_W = $clog2(DIV);
    localparam int IDX_W = $clog2(FRAME_LEN);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DIV / 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_HALF = IDX_W'(FRAME_LEN / 2);
    // One extra bit so SYNC_LEN == FRAME_LEN still fits.
    localparam logic [IDX_W:0]   SYNC_END = (IDX_W + 1)'(SYNC_LEN);
    localparam logic [6:0]       LFSR_SEED = 7'h7F;

    typedef enum logic [1:0] {
        MODE_SQUARE = 2'd0,
        MODE_TOGGLE = 2'd1,
        MODE_PRBS   = 2'd2,
        MODE_LOW    = 2'd3
    } mode_t;

    logic [DIV_W-1:0]     div;
    logic [IDX_W-1:0]     idx;
    logic [DATA_NBIT-1:0] ramp;
    logic [6:0]           lfsr;
    mode_t                mode_q;
    logic                 en_q;

    logic                 tick;
    logic                 en_rise;
    mode_t                mode_eff;
    logic                 base_cur;
    logic [NCHN-1:0]      stag;

    assign tick    = (div == DIV_LAST);
    assign en_rise = pg.en && !en_q;

    // On the enable edge mode_q is only being loaded, so the first sample
    // already uses the incoming mode.
    always_comb begin
        mode_eff = en_rise ? mode_t'(pg.mode) : mode_q;
        base_cur = 1'b0;
        case (mode_eff)
            MODE_SQUARE: base_cur = (idx < IDX_HALF);
            MODE_TOGGLE: base_cur = ~idx[0];
            MODE_PRBS:   base_cur = lfsr[6];
            default:     base_cur = 1'b0;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            div    <= '0;
            idx    <= '0;
            ramp   <= '0;
            lfsr   <= LFSR_SEED;
            mode_q <= MODE_SQUARE;
            en_q   <= 1'b0;
        end else begin
            en_q <= pg.en;
            if (!pg.en) begin
                div  <= '0;
                idx  <= '0;
                lfsr <= LFSR_SEED;
            end else begin
                div <= tick ? '0 : div + 1'b1;
                if (tick) begin
                    idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    ramp <= ramp + 1'b1;
                    lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
                end
                if (en_rise || (tick && idx == IDX_LAST))
                    mode_q <= mode_t'(pg.mode);
            end
        end
    end

    // stag[k] is base(i-k); the history shifts one place per sample.
    generate
        if (NCHN > 1) begin : g_dly
            logic [NCHN-2:0] dly;
            always_ff @(posedge mclk) begin
                if (rst || !pg.en)
                    dly <= '0;
                else if (tick)
                    dly <= stag[NCHN-2:0];
            end
            assign stag = {dly, base_cur};
        end else begin : g_nodly
            assign stag = base_cur;
        end
    endgenerate

    always_ff @(posedge mclk) begin
        if (rst || !pg.en) begin
            pg.out_spclk   <= 1'b0;
            pg.out_sync    <= 1'b0;
            pg.out_data    <= '0;
            pg.frame_start <= 1'b0;
            pg.pat_vd      <= 1'b0;
            pg.pat_data    <= '0;
        end else begin
            pg.out_spclk   <= (div < DIV_HALF);
            pg.out_sync    <= ({1'b0, idx} < SYNC_END);
            pg.out_data    <= stag;
            pg.frame_start <= (div == '0) && (idx == '0);
            pg.pat_vd      <= (div == '0);
            pg.pat_data    <= ramp;
        end
    end

endmodule

// File: doc/sync_pattern_gen.md
Name: sync_pattern_gen

Overview:
- Parametrised frame-sync, sample-clock and test-pattern generator for bench stimulus of the ADC acquisition path (ad_cache / cmd_decode).
- Successor to the fixed single-channel SYNC OUT logic. Adds configurable divider, frame and sync length, NCHN phase-staggered data channels, selectable pattern modes, enable gating, a ramp data word, and frame-boundary mode switching.
- Runs entirely on mclk.

Parameters:
- DIV, 500, mclk cycles per sample period (100 MHz / 200 kHz); must be >= 2.
- FRAME_LEN, 512, samples per frame; must be >= 2 and even.
- SYNC_LEN, 9, samples per frame with out_sync high; 1..FRAME_LEN.
- NCHN, 1, number of serial data outputs; 1..16.
- DATA_NBIT, 18, width of the ramp data word.

Ports:
- mclk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  generator enable.
- mode  input  2  pattern select: 0 square, 1 toggle, 2 PRBS7, 3 constant low.
- out_spclk  output  1  simulated sample clock.
- out_sync  output  1  simulated frame sync.
- out_data  output  NCHN  simulated serial data; bit k is channel k.
- frame_start  output  1  one-cycle pulse at the first mclk of each frame.
- pat_vd  output  1  one-cycle strobe at the first mclk of each sample.
- pat_data  output  DATA_NBIT  ramp word, valid with pat_vd.

Behaviour:
- Clock and reset: one clock, mclk. rst is synchronous and active-high.
- Reset values: all outputs 0; div=0, idx=0, ramp=0, lfsr=7'h7F, mode_q=0, delay line cleared.
- Counters:
  - div counts 0..DIV-1, then wraps to 0.
  - tick = (div==DIV-1). On tick, idx advances 0..FRAME_LEN-1 and wraps to 0.
- Enable:
  - en=0: div, idx and the delay line are held at 0, lfsr is held at its seed, and all outputs are driven 0 on the next cycle. ramp keeps its value.
  - en 0->1: counting starts from div=0, idx=0.
  - en 1->0 mid-frame: the frame is aborted immediately; no pulse completes.
- Outputs are registered from the current counter state, 1 mclk latency:
  - out_spclk = (div < DIV/2), using integer division.
  - out_sync = (idx < SYNC_LEN).
  - frame_start = (div==0 && idx==0).
  - pat_vd = (div==0).
  - pat_data = ramp. ramp increments by 1 on each tick and wraps modulo 2^DATA_NBIT.
- Mode latch:
  - mode_q <= mode when en rises, and on a tick where idx==FRAME_LEN-1.
  - A mode change mid-frame takes effect only at the next frame start.
- Base pattern for sample i, using mode_q:
  - square: 1 when i < FRAME_LEN/2, i.e. samples 0..FRAME_LEN/2-1 high. The prior off-by-one is corrected.
  - toggle: 1 when i is even.
  - PRBS7: polynomial x^7+x^6+1, output bit lfsr[6], advanced once per tick. Free-running across frames; not reseeded per frame.
  - constant low: 0.
- Channel stagger:
  - During sample i, out_data[k] = base(i-k). Samples before the first enabled sample count as 0.
  - Each sample's base value therefore appears on channel k exactly k sample periods later.
  - The delay line shifts on tick and carries across frame boundaries.
- Simultaneous events: rst has priority over en. en=0 has priority over tick and mode latch.
- Widths: idx is $clog2(FRAME_LEN) bits; div is $clog2(DIV) bits.

Test Plan:
Bench parameters: DIV=10, FRAME_LEN=16, SYNC_LEN=3, NCHN=4, DATA_NBIT=8.
1. Reset then en=1, mode=0:
   - out_spclk is high for 5 mclk and low for 5 mclk, period 10.
   - out_sync is high for 30 mclk, then low for 130 mclk.
   - frame_start pulses every 160 mclk.
   - out_data[0] is high for samples 0..7 and low for 8..15.
2. Stagger, mode=0:
   - out_data[3] rises exactly 30 mclk after out_data[0] in the second frame.
   - In the first frame, out_data[3] stays 0 for samples 0..2.
3. pat_data:
   - pat_vd pulses every 10 mclk.
   - pat_data reads 0,1,2,...,255,0 across 256 samples, with no gaps.
4. Mode switch mode 0->1 at sample 5:
   - Square continues to sample 15.
   - From the next frame_start, out_data[0] is 1,0,1,0...
5. mode=2:
   - The first 8 out_data[0] bits match a reference LFSR seeded 7'h7F.
   - The sequence repeats every 127 samples.
6. Reset mid-frame at sample 9: all outputs are 0 on the next cycle, and the first frame_start follows 1 cycle after rst deasserts with en=1. en=0 at sample 9: all outputs are 0 on the next cycle. Re-enable restarts with a full frame and a fresh sync.
